// File: rtl/ex_stage_pkg.sv
// Shared types for the execute stage: ALU op encodings, MUL FSM states, EX/MEM control bundle.
// alu_decode turns the ID/EX aluop and {instr[30], funct3} into a concrete ALU operation.
package ex_stage_pkg;

    localparam int XLEN_DEF = 64;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b1000,
        ALU_AND  = 4'b0111,
        ALU_OR   = 4'b0110,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0001,
        ALU_SRL  = 4'b0101,
        ALU_SRA  = 4'b1101,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mul_state_e;

    typedef struct packed {
        logic branch;
        logic memread;
        logic memtoreg;
        logic memwrite;
        logic regwrite;
    } ctrl_t;

    // I-type immediates put arbitrary data in bit 30; it only selects SRAI vs SRLI.
    function automatic alu_op_e alu_decode(input logic [1:0] aluop, input logic [3:0] funct);
        logic [3:0] f;
        f = funct;
        if (aluop == ALUOP_ITYPE && funct[2:0] != 3'b101) f = {1'b0, funct[2:0]};
        case (aluop)
            ALUOP_ADD: return ALU_ADD;
            ALUOP_SUB: return ALU_SUB;
            default: begin
                case (f)
                    4'b1000: return ALU_SUB;
                    4'b0111: return ALU_AND;
                    4'b0110: return ALU_OR;
                    4'b0100: return ALU_XOR;
                    4'b0001: return ALU_SLL;
                    4'b0101: return ALU_SRL;
                    4'b1101: return ALU_SRA;
                    4'b0010: return ALU_SLT;
                    4'b0011: return ALU_SLTU;
                    default: return ALU_ADD;
                endcase
            end
        endcase
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs, MEM/WB forwarding sources and EX/MEM outputs of the execute stage.
interface ex_stage_if #(parameter int XLEN = 64);
    logic [XLEN-1:0] pc_ex, rdata1_ex, rdata2_ex, imm_ex;
    logic [4:0]      rs1_ex, rs2_ex, rd_ex;
    logic [3:0]      funct_ex;
    logic [1:0]      aluop_ex;
    logic            alusrc_ex, mul_ex;
    logic            branch_ex, memread_ex, memtoreg_ex, memwrite_ex, regwrite_ex;
    logic [4:0]      memwb_rd;
    logic            memwb_regwrite;
    logic [XLEN-1:0] memwb_wdata;
    logic            ex_flush;
    logic [XLEN-1:0] mem_branch_tgt, mem_alu_result, mem_store_data;
    logic            mem_zero;
    logic [4:0]      mem_rd;
    logic            mem_branch, mem_memread, mem_memtoreg, mem_memwrite, mem_regwrite;
    logic            ex_stall;

    modport master (
        output pc_ex, rdata1_ex, rdata2_ex, imm_ex, rs1_ex, rs2_ex, rd_ex, funct_ex, aluop_ex,
               alusrc_ex, mul_ex, branch_ex, memread_ex, memtoreg_ex, memwrite_ex, regwrite_ex,
               memwb_rd, memwb_regwrite, memwb_wdata, ex_flush,
        input  mem_branch_tgt, mem_alu_result, mem_store_data, mem_zero, mem_rd,
               mem_branch, mem_memread, mem_memtoreg, mem_memwrite, mem_regwrite, ex_stall
    );

    modport slave (
        input  pc_ex, rdata1_ex, rdata2_ex, imm_ex, rs1_ex, rs2_ex, rd_ex, funct_ex, aluop_ex,
               alusrc_ex, mul_ex, branch_ex, memread_ex, memtoreg_ex, memwrite_ex, regwrite_ex,
               memwb_rd, memwb_regwrite, memwb_wdata, ex_flush,
        output mem_branch_tgt, mem_alu_result, mem_store_data, mem_zero, mem_rd,
               mem_branch, mem_memread, mem_memtoreg, mem_memwrite, mem_regwrite, ex_stall
    );
endinterface

// File: rtl/ex_stage_mul_iter.sv
// Radix-2 shift-add multiplier, one partial product per i_step; keeps the low XLEN product bits.
// o_done marks the step that consumes the last multiplier bit (terminal count of a down-counter).
module ex_stage_mul_iter #(
    parameter int XLEN  = 64,
    parameter int ITERS = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_start,
    input  logic            i_step,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_done,
    output logic [XLEN-1:0] o_product
);
    localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_mcand, r_mplier, r_acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (i_start) begin
            r_cnt    <= CW'(ITERS - 1);
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_acc    <= '0;
        end else if (i_step) begin
            r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_done    = (r_cnt == '0);
    assign o_product = r_acc;
endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch target, iterative MUL sequencing and the EX/MEM register.
// MUL FSM:  IDLE | single-cycle ops flow; MUL issue latches operands
//           BUSY | one shift-add step per cycle, upstream stalled, bubbles to EX/MEM
//           DONE | product written to EX/MEM with latched rd/control
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int MUL_ITERS = XLEN
) (
    input logic        clk,
    input logic        reset,
    ex_stage_if.slave  bus
);
    localparam int SHW = $clog2(XLEN);

    mul_state_e      r_state, w_state_nxt;
    logic [XLEN-1:0] w_fwd_a, w_fwd_b, w_op_b, w_alu, w_product;
    logic [SHW-1:0]  w_shamt;
    alu_op_e         w_alu_op;
    ctrl_t           w_ctrl_ex;
    logic            w_start, w_step, w_stall, w_sel_mul, w_bubble, w_mul_done;

    logic [XLEN-1:0] r_alu_result, r_store_data, r_branch_tgt, r_mul_store;
    logic            r_zero;
    logic [4:0]      r_rd, r_mul_rd;
    ctrl_t           r_ctrl, r_mul_ctrl;

    assign w_ctrl_ex = {bus.branch_ex, bus.memread_ex, bus.memtoreg_ex, bus.memwrite_ex, bus.regwrite_ex};

    // A load in EX/MEM has no data yet; the hazard unit upstream already stalled for it.
    always_comb begin
        w_fwd_a = bus.rdata1_ex;
        if (r_ctrl.regwrite && !r_ctrl.memtoreg && r_rd != 5'd0 && r_rd == bus.rs1_ex)
            w_fwd_a = r_alu_result;
        else if (bus.memwb_regwrite && bus.memwb_rd != 5'd0 && bus.memwb_rd == bus.rs1_ex)
            w_fwd_a = bus.memwb_wdata;
        w_fwd_b = bus.rdata2_ex;
        if (r_ctrl.regwrite && !r_ctrl.memtoreg && r_rd != 5'd0 && r_rd == bus.rs2_ex)
            w_fwd_b = r_alu_result;
        else if (bus.memwb_regwrite && bus.memwb_rd != 5'd0 && bus.memwb_rd == bus.rs2_ex)
            w_fwd_b = bus.memwb_wdata;
    end

    assign w_op_b   = bus.alusrc_ex ? bus.imm_ex : w_fwd_b;
    assign w_shamt  = w_op_b[SHW-1:0];
    assign w_alu_op = alu_decode(bus.aluop_ex, bus.funct_ex);

    always_comb begin
        w_alu = '0;
        case (w_alu_op)
            ALU_ADD:  w_alu = w_fwd_a + w_op_b;
            ALU_SUB:  w_alu = w_fwd_a - w_op_b;
            ALU_AND:  w_alu = w_fwd_a & w_op_b;
            ALU_OR:   w_alu = w_fwd_a | w_op_b;
            ALU_XOR:  w_alu = w_fwd_a ^ w_op_b;
            ALU_SLL:  w_alu = w_fwd_a << w_shamt;
            ALU_SRL:  w_alu = w_fwd_a >> w_shamt;
            ALU_SRA:  w_alu = XLEN'($signed(w_fwd_a) >>> w_shamt);
            ALU_SLT:  w_alu = {{(XLEN-1){1'b0}}, $signed(w_fwd_a) < $signed(w_op_b)};
            ALU_SLTU: w_alu = {{(XLEN-1){1'b0}}, w_fwd_a < w_op_b};
            default:  w_alu = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.mul_ex && !bus.ex_flush) w_state_nxt = BUSY;
            BUSY:    if (bus.ex_flush) w_state_nxt = IDLE;
                     else if (w_mul_done) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_start   = 1'b0;
        w_step    = 1'b0;
        w_stall   = 1'b0;
        w_sel_mul = 1'b0;
        w_bubble  = bus.ex_flush;
        case (r_state)
            IDLE: begin
                w_start  = bus.mul_ex && !bus.ex_flush;
                w_stall  = w_start;
                w_bubble = bus.ex_flush || w_start;
            end
            BUSY: begin
                w_step   = !bus.ex_flush;
                w_stall  = !bus.ex_flush;
                w_bubble = 1'b1;
            end
            DONE:    w_sel_mul = !bus.ex_flush;
            default: ;
        endcase
    end

    // Reset must release the upstream stages even if ID/EX still presents a MUL.
    assign bus.ex_stall = w_stall && !reset;

    ex_stage_mul_iter #(.XLEN(XLEN), .ITERS(MUL_ITERS)) u_mul (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_start),
        .i_step    (w_step),
        .i_a       (w_fwd_a),
        .i_b       (w_fwd_b),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mul_rd    <= '0;
            r_mul_ctrl  <= '0;
            r_mul_store <= '0;
        end else if (w_start) begin
            r_mul_rd    <= bus.rd_ex;
            r_mul_ctrl  <= w_ctrl_ex;
            r_mul_store <= w_fwd_b;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alu_result <= '0;
            r_store_data <= '0;
            r_branch_tgt <= '0;
            r_zero       <= 1'b0;
            r_rd         <= '0;
            r_ctrl       <= '0;
        end else begin
            r_branch_tgt <= bus.pc_ex + (bus.imm_ex << 1);
            if (w_sel_mul) begin
                r_alu_result <= w_product;
                r_zero       <= (w_product == '0);
                r_rd         <= r_mul_rd;
                r_store_data <= r_mul_store;
                r_ctrl       <= r_mul_ctrl;
            end else begin
                r_alu_result <= w_alu;
                r_zero       <= (w_alu == '0);
                r_rd         <= bus.rd_ex;
                r_store_data <= w_fwd_b;
                r_ctrl       <= w_bubble ? '0 : w_ctrl_ex;
            end
        end
    end

    assign bus.mem_alu_result = r_alu_result;
    assign bus.mem_store_data = r_store_data;
    assign bus.mem_branch_tgt = r_branch_tgt;
    assign bus.mem_zero       = r_zero;
    assign bus.mem_rd         = r_rd;
    assign bus.mem_branch     = r_ctrl.branch;
    assign bus.mem_memread    = r_ctrl.memread;
    assign bus.mem_memtoreg   = r_ctrl.memtoreg;
    assign bus.mem_memwrite   = r_ctrl.memwrite;
    assign bus.mem_regwrite   = r_ctrl.regwrite;
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: forwarding, ALU decode, shifts, flush, MUL latency/abort/reset.
module tb_ex_stage;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    ex_stage_if #(.XLEN(64)) bus ();

    ex_stage #(.XLEN(64), .MUL_ITERS(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [63:0] a, input logic [63:0] b, input logic [63:0] imm,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [3:0] funct, input logic [1:0] aluop, input logic alusrc,
                             input logic mul, input logic regwrite);
        bus.pc_ex       = 64'h100;
        bus.rdata1_ex   = a;
        bus.rdata2_ex   = b;
        bus.imm_ex      = imm;
        bus.rs1_ex      = rs1;
        bus.rs2_ex      = rs2;
        bus.rd_ex       = rd;
        bus.funct_ex    = funct;
        bus.aluop_ex    = aluop;
        bus.alusrc_ex   = alusrc;
        bus.mul_ex      = mul;
        bus.branch_ex   = 1'b0;
        bus.memread_ex  = 1'b0;
        bus.memtoreg_ex = 1'b0;
        bus.memwrite_ex = 1'b0;
        bus.regwrite_ex = regwrite;
    endtask

    task automatic set_memwb(input logic [4:0] rd, input logic we, input logic [63:0] wdata);
        bus.memwb_rd       = rd;
        bus.memwb_regwrite = we;
        bus.memwb_wdata    = wdata;
    endtask

    // Steps while ex_stall is high (bounded); reports cycles counted and whether EX/MEM stayed a bubble.
    task automatic run_stall(output int n, output bit bubble_ok);
        n = 0;
        bubble_ok = 1'b1;
        while (bus.ex_stall === 1'b1 && n < 200) begin
            step();
            n++;
            if (bus.mem_regwrite !== 1'b0) bubble_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        set_instr(64'd0, 64'd0, 64'd0, 5'd0, 5'd0, 5'd0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        set_memwb(5'd0, 1'b0, 64'd0);
        bus.ex_flush = 1'b0;
        #3;
        n_checks++;
        if ({bus.mem_alu_result, bus.mem_store_data, bus.mem_branch_tgt} !== 192'd0)
            $display("FAIL reset_data got %h/%h/%h want 0", bus.mem_alu_result, bus.mem_store_data, bus.mem_branch_tgt);
        else n_pass++;
        n_checks++;
        if ({bus.mem_rd, bus.mem_zero, bus.mem_branch, bus.mem_memread, bus.mem_memtoreg,
             bus.mem_memwrite, bus.mem_regwrite, bus.ex_stall} !== 12'd0)
            $display("FAIL reset_ctrl got rd=%0d regwrite=%b stall=%b want 0", bus.mem_rd, bus.mem_regwrite, bus.ex_stall);
        else n_pass++;
        #9 reset = 1'b0;
    endtask

    task automatic test_add();
        set_instr(64'd5, 64'd7, 64'd7, 5'd1, 5'd2, 5'd3, 4'b0000, 2'b10, 1'b0, 1'b0, 1'b1);
        step();
        n_checks++;
        if (bus.mem_alu_result !== 64'd12) $display("FAIL add_result got %0d want 12", bus.mem_alu_result);
        else n_pass++;
        n_checks++;
        if (bus.mem_rd !== 5'd3 || bus.mem_regwrite !== 1'b1 || bus.mem_zero !== 1'b0)
            $display("FAIL add_ctrl got rd=%0d we=%b zero=%b want 3/1/0", bus.mem_rd, bus.mem_regwrite, bus.mem_zero);
        else n_pass++;
        n_checks++;
        if (bus.mem_branch_tgt !== 64'h10E || bus.mem_store_data !== 64'd7)
            $display("FAIL add_tgt got tgt=%h sd=%0d want 10e/7", bus.mem_branch_tgt, bus.mem_store_data);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        set_instr(64'd0, 64'd5, 64'd0, 5'd3, 5'd1, 5'd4, 4'b1000, 2'b10, 1'b0, 1'b0, 1'b1);
        set_memwb(5'd3, 1'b1, 64'd0);
        step();
        n_checks++;
        if (bus.mem_alu_result !== 64'd7 || bus.mem_rd !== 5'd4)
            $display("FAIL fwd_exmem got %0d rd=%0d want 7 rd=4", bus.mem_alu_result, bus.mem_rd);
        else n_pass++;
        set_instr(64'd1, 64'd0, 64'd5, 5'd9, 5'd0, 5'd5, 4'b0000, 2'b11, 1'b1, 1'b0, 1'b1);
        set_memwb(5'd9, 1'b1, 64'd100);
        step();
        n_checks++;
        if (bus.mem_alu_result !== 64'd105) $display("FAIL fwd_memwb got %0d want 105", bus.mem_alu_result);
        else n_pass++;
        set_memwb(5'd0, 1'b0, 64'd0);
    endtask

    task automatic test_alu_ops();
        set_instr(64'h8000_0000_0000_0000, 64'd0, 64'd4, 5'd0, 5'd0, 5'd6, 4'b1101, 2'b10, 1'b1, 1'b0, 1'b1);
        step();
        n_checks++;
        if (bus.mem_alu_result !== 64'hF800_0000_0000_0000) $display("FAIL sra got %h want f800000000000000", bus.mem_alu_result);
        else n_pass++;
        bus.funct_ex = 4'b0101;
        step();
        n_checks++;
        if (bus.mem_alu_result !== 64'h0800_0000_0000_0000) $display("FAIL srl got %h want 0800000000000000", bus.mem_alu_result);
        else n_pass++;
        bus.aluop_ex = 2'b11;
        bus.funct_ex = 4'b1101;
        step();
        n_checks++;
        if (bus.mem_alu_result !== 64'hF800_0000_0000_0000) $display("FAIL srai got %h want f800000000000000", bus.mem_alu_result);
        else n_pass++;
        set_instr(64'd10, 64'd0, 64'd3, 5'd0, 5'd0, 5'd6, 4'b1000, 2'b11, 1'b1, 1'b0, 1'b1);
        step();
        n_checks++;
        if (bus.mem_alu_result !== 64'd13) $display("FAIL addi_bit30 got %0d want 13", bus.mem_alu_result);
        else n_pass++;
        set_instr(64'd3, 64'd5, 64'd0, 5'd0, 5'd0, 5'd6, 4'b0111, 2'b01, 1'b0, 1'b0, 1'b1);
        step();
        n_checks++;
        if (bus.mem_alu_result !== 64'hFFFF_FFFF_FFFF_FFFE) $display("FAIL aluop_sub got %h want fffffffffffffffe", bus.mem_alu_result);
        else n_pass++;
        set_instr(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd1, 5'd0, 5'd0, 5'd6, 4'b0010, 2'b10, 1'b1, 1'b0, 1'b1);
        step();
        n_checks++;
        if (bus.mem_alu_result !== 64'd1 || bus.mem_zero !== 1'b0) $display("FAIL slt got %0d zero=%b want 1/0", bus.mem_alu_result, bus.mem_zero);
        else n_pass++;
        bus.funct_ex = 4'b0011;
        step();
        n_checks++;
        if (bus.mem_alu_result !== 64'd0 || bus.mem_zero !== 1'b1) $display("FAIL sltu got %0d zero=%b want 0/1", bus.mem_alu_result, bus.mem_zero);
        else n_pass++;
        set_instr(64'hF0F0, 64'h0FF0, 64'd0, 5'd0, 5'd0, 5'd6, 4'b0100, 2'b10, 1'b0, 1'b0, 1'b1);
        step();
        n_checks++;
        if (bus.mem_alu_result !== 64'hFF00) $display("FAIL xor got %h want ff00", bus.mem_alu_result);
        else n_pass++;
    endtask

    task automatic test_flush();
        set_instr(64'd1, 64'd2, 64'd0, 5'd0, 5'd0, 5'd7, 4'b0000, 2'b10, 1'b0, 1'b0, 1'b1);
        bus.ex_flush = 1'b1;
        step();
        n_checks++;
        if (bus.mem_regwrite !== 1'b0) $display("FAIL flush_bubble got regwrite=%b want 0", bus.mem_regwrite);
        else n_pass++;
        bus.ex_flush = 1'b0;
    endtask

    task automatic test_mul();
        int n;
        bit ok;
        set_instr(64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'd0, 5'd5, 5'd6, 5'd7, 4'b0000, 2'b10, 1'b0, 1'b1, 1'b1);
        #1;
        step();
        // Operands must already be latched; upstream values and MEM/WB now change under the multiplier.
        bus.rdata1_ex = 64'd0;
        bus.rdata2_ex = 64'd0;
        set_memwb(5'd5, 1'b1, 64'd123);
        run_stall(n, ok);
        n_checks++;
        if (n + 1 !== 65) $display("FAIL mul_stall_len got %0d want 65", n + 1);
        else n_pass++;
        n_checks++;
        if (!ok || bus.mem_regwrite !== 1'b0) $display("FAIL mul_bubbles got regwrite high during stall");
        else n_pass++;
        step();
        n_checks++;
        if (bus.mem_alu_result !== 64'hFFFF_FFFF_FFFF_FFFD) $display("FAIL mul_result got %h want fffffffffffffffd", bus.mem_alu_result);
        else n_pass++;
        n_checks++;
        if (bus.mem_rd !== 5'd7 || bus.mem_regwrite !== 1'b1) $display("FAIL mul_ctrl got rd=%0d we=%b want 7/1", bus.mem_rd, bus.mem_regwrite);
        else n_pass++;
        bus.mul_ex = 1'b0;
        set_memwb(5'd0, 1'b0, 64'd0);
        #1;
        n_checks++;
        if (bus.ex_stall !== 1'b0) $display("FAIL mul_no_restart got stall=%b want 0", bus.ex_stall);
        else n_pass++;
        step();
    endtask

    task automatic test_mul_flush();
        bit seen_we = 1'b0;
        set_instr(64'd6, 64'd7, 64'd0, 5'd0, 5'd0, 5'd8, 4'b0000, 2'b10, 1'b0, 1'b1, 1'b1);
        step();
        for (int i = 0; i < 10; i++) step();
        bus.ex_flush = 1'b1;
        step();
        bus.ex_flush = 1'b0;
        set_instr(64'd0, 64'd0, 64'd0, 5'd0, 5'd0, 5'd0, 4'b0000, 2'b10, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (bus.ex_stall !== 1'b0 || bus.mem_regwrite !== 1'b0)
            $display("FAIL mul_abort got stall=%b we=%b want 0/0", bus.ex_stall, bus.mem_regwrite);
        else n_pass++;
        for (int i = 0; i < 70; i++) begin
            step();
            if (bus.mem_regwrite !== 1'b0 || bus.mem_alu_result === 64'd42) seen_we = 1'b1;
        end
        n_checks++;
        if (seen_we) $display("FAIL mul_abort_result got aborted MUL written back, want none");
        else n_pass++;
    endtask

    task automatic test_reset_mid_mul();
        int n;
        bit ok;
        set_instr(64'd9, 64'd11, 64'd0, 5'd0, 5'd0, 5'd9, 4'b0000, 2'b10, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 21; i++) step();
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.mem_alu_result, bus.mem_branch_tgt, bus.mem_store_data} !== 192'd0 || bus.mem_rd !== 5'd0 ||
            bus.mem_regwrite !== 1'b0 || bus.ex_stall !== 1'b0)
            $display("FAIL reset_mid_mul got res=%h rd=%0d stall=%b want 0", bus.mem_alu_result, bus.mem_rd, bus.ex_stall);
        else n_pass++;
        set_instr(64'd12, 64'd13, 64'd0, 5'd0, 5'd0, 5'd10, 4'b0000, 2'b10, 1'b0, 1'b1, 1'b1);
        #2 reset = 1'b0;
        #1;
        run_stall(n, ok);
        n_checks++;
        if (n !== 65 || !ok) $display("FAIL remul_stall got %0d bubble_ok=%b want 65/1", n, ok);
        else n_pass++;
        step();
        n_checks++;
        if (bus.mem_alu_result !== 64'd156 || bus.mem_rd !== 5'd10 || bus.mem_regwrite !== 1'b1)
            $display("FAIL remul_result got %0d rd=%0d we=%b want 156/10/1", bus.mem_alu_result, bus.mem_rd, bus.mem_regwrite);
        else n_pass++;
        bus.mul_ex = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_alu_ops();
        test_flush();
        test_mul();
        test_mul_flush();
        test_reset_mid_mul();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
